// File: rtl/decode_stage.sv
// decode_stage
// Registered, flow-controlled RV32I decode stage sitting between fetch and
// execute. Each accepted instruction is split into its fields, gets its
// sign-extended immediate and register-use flags, and is registered together
// with its PC. A two-entry skid buffer (main + skid) keeps in_ready a pure
// register output (in_ready = !skid_valid), independent of out_ready.
//
// Optional feature: define DECODE_ILLEGAL_EN to register an illegal-instruction
// flag with the payload. Left undefined, the illegal output is tied to 0.
//
// Parameters:
//   XLEN  width of the immediate output (>= 32), sign-extended from bit 31
//   PC_W  width of the PC carried with each instruction
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               drop everything buffered and the input of this cycle
//   in_valid/in_ready   fetch-side handshake; in_instr, in_pc payload
//   out_valid/out_ready execute-side handshake
//   out_pc, opcode, func3, func7, Rs1, Rs2, Rd, imme  decoded payload
//   imm_fmt             0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//   rs1_used, rs2_used, rd_we, illegal  register-use / legality flags

module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic            func7,
    output logic [4:0]      Rs1,
    output logic [4:0]      Rs2,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] imme,
    output logic [2:0]      imm_fmt,
    output logic            rs1_used,
    output logic            rs2_used,
    output logic            rd_we,
    output logic            illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic            func7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_we;
`ifdef DECODE_ILLEGAL_EN
        logic            illegal;
`endif
    } payload_t;

    logic            r_out_valid;
    logic            r_skid_valid;
    logic [31:0]     r_skid_instr;
    logic [PC_W-1:0] r_skid_pc;
    payload_t        r_main;

    logic [31:0]     w_src_instr;
    logic [PC_W-1:0] w_src_pc;
    logic [31:0]     w_imm32;
    logic            w_is_op;
    payload_t        w_dec;
    logic            w_accept;
    logic            w_load_main;

    // The skid holds the raw word; whichever entry heads into main is decoded.
    assign w_src_instr = r_skid_valid ? r_skid_instr : in_instr;
    assign w_src_pc    = r_skid_valid ? r_skid_pc    : in_pc;

    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && !r_skid_valid;
    assign w_load_main = !r_out_valid || out_ready;

    always_comb begin
        w_dec         = '0;
        w_imm32       = '0;
        w_is_op       = 1'b0;
        w_dec.pc      = w_src_pc;
        w_dec.opcode  = w_src_instr[6:0];
        w_dec.func3   = w_src_instr[14:12];
        w_dec.func7   = w_src_instr[30];
        w_dec.rs1     = w_src_instr[19:15];
        w_dec.rs2     = w_src_instr[24:20];
        w_dec.rd      = w_src_instr[11:7];

        case (w_src_instr[6:0])
            OPC_LUI, OPC_AUIPC:           w_dec.fmt = FMT_U;
            OPC_JAL:                      w_dec.fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: w_dec.fmt = FMT_I;
            OPC_BRANCH:                   w_dec.fmt = FMT_B;
            OPC_STORE:                    w_dec.fmt = FMT_S;
            OPC_OP:                       w_is_op   = 1'b1;
            default:                      w_dec.fmt = FMT_NONE;
        endcase

        case (w_dec.fmt)
            FMT_I:   w_imm32 = {{20{w_src_instr[31]}}, w_src_instr[31:20]};
            FMT_S:   w_imm32 = {{20{w_src_instr[31]}}, w_src_instr[31:25], w_src_instr[11:7]};
            FMT_B:   w_imm32 = {{19{w_src_instr[31]}}, w_src_instr[31], w_src_instr[7],
                                w_src_instr[30:25], w_src_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {w_src_instr[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{w_src_instr[31]}}, w_src_instr[31], w_src_instr[19:12],
                                w_src_instr[20], w_src_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase

        // U immediates also sign-extend from bit 31 on wider datapaths.
        w_dec.imm       = {XLEN{w_imm32[31]}};
        w_dec.imm[31:0] = w_imm32;

        w_dec.rs1_used = (w_dec.fmt == FMT_I) || (w_dec.fmt == FMT_S) ||
                         (w_dec.fmt == FMT_B) || w_is_op;
        w_dec.rs2_used = (w_dec.fmt == FMT_S) || (w_dec.fmt == FMT_B) || w_is_op;
        w_dec.rd_we    = ((w_dec.fmt == FMT_U) || (w_dec.fmt == FMT_J) ||
                          (w_dec.fmt == FMT_I) || w_is_op) && (w_dec.rd != 5'd0);

`ifdef DECODE_ILLEGAL_EN
        // Every recognised opcode either has a format or is OP.
        w_dec.illegal = !((w_dec.fmt != FMT_NONE) || w_is_op) ||
                        (w_src_instr[1:0] != 2'b11) ||
                        ((w_dec.opcode == OPC_JALR) && (w_dec.func3 != 3'd0)) ||
                        ((w_dec.opcode == OPC_BRANCH) && (w_dec.func3[2:1] == 2'b01)) ||
                        (w_is_op && (w_src_instr[31:25] != 7'b0000000) &&
                                    (w_src_instr[31:25] != 7'b0100000));
        if (w_dec.illegal) begin
            w_dec.rs1_used = 1'b0;
            w_dec.rs2_used = 1'b0;
            w_dec.rd_we    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_main       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_out_valid <= r_skid_valid || w_accept;
                if (r_skid_valid || w_accept) begin
                    r_main <= w_dec;
                end
            end
            // An accept can only happen with the skid empty, so a skid entry
            // moving to main never coincides with a new arrival.
            if (w_accept && !w_load_main) begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= in_instr;
                r_skid_pc    <= in_pc;
            end else if (w_load_main) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_pc    = r_main.pc;
    assign opcode    = r_main.opcode;
    assign func3     = r_main.func3;
    assign func7     = r_main.func7;
    assign Rs1       = r_main.rs1;
    assign Rs2       = r_main.rs2;
    assign Rd        = r_main.rd;
    assign imme      = r_main.imm;
    assign imm_fmt   = r_main.fmt;
    assign rs1_used  = r_main.rs1_used;
    assign rs2_used  = r_main.rs2_used;
    assign rd_we     = r_main.rd_we;
`ifdef DECODE_ILLEGAL_EN
    assign illegal   = r_main.illegal;
`else
    assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: a directed vector table, hand-written stall and
// flush sequences, then randomized traffic against a queue-based model.
// Two instances share the stimulus: XLEN=32 and XLEN=64.

module tb_decode_stage;

`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, func7, rs1_used, rs2_used, rd_we, illegal;
    logic [31:0] out_pc, imme;
    logic [6:0]  opcode;
    logic [2:0]  func3, imm_fmt;
    logic [4:0]  Rs1, Rs2, Rd;

    logic        in_ready_w, out_valid_w, func7_w, rs1_used_w, rs2_used_w, rd_we_w, illegal_w;
    logic [31:0] out_pc_w;
    logic [63:0] imme_w;
    logic [6:0]  opcode_w;
    logic [2:0]  func3_w, imm_fmt_w;
    logic [4:0]  Rs1_w, Rs2_w, Rd_w;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .func3(func3), .func7(func7),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .imme(imme), .imm_fmt(imm_fmt),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_we(rd_we), .illegal(illegal)
    );

    decode_stage #(.XLEN(64), .PC_W(32)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_pc(out_pc_w),
        .opcode(opcode_w), .func3(func3_w), .func7(func7_w),
        .Rs1(Rs1_w), .Rs2(Rs2_w), .Rd(Rd_w), .imme(imme_w), .imm_fmt(imm_fmt_w),
        .rs1_used(rs1_used_w), .rs2_used(rs2_used_w), .rd_we(rd_we_w), .illegal(illegal_w)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic        rs1u;
        logic        rs2u;
        logic        rdwe;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        rs1u;
        logic        rs2u;
        logic        rdwe;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                            7'b0010011, 7'b1100011, 7'b0100011, 7'b0110011};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Two's-complement value of the low 'bits' bits of v, as a 64-bit number.
    function automatic logic [63:0] sext(input logic [31:0] v, input int bits);
        logic [63:0] m;
        m = {32'b0, v} & ((64'd1 << bits) - 64'd1);
        if (v[bits-1]) m = m - (64'd1 << bits);
        return m;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        bit known;
        op = w[6:0];
        f3 = w[14:12];
        known = 1'b1;
        e.fmt = 3'd0;
        e.imm = 64'd0;
        case (op)
            7'b0110111, 7'b0010111: begin e.fmt = 3'd4; e.imm = sext({w[31:12], 12'b0}, 32); end
            7'b1101111: begin e.fmt = 3'd5; e.imm = sext({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); end
            7'b1100111, 7'b0000011, 7'b0010011: begin e.fmt = 3'd1; e.imm = sext({20'b0, w[31:20]}, 12); end
            7'b1100011: begin e.fmt = 3'd3; e.imm = sext({19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13); end
            7'b0100011: begin e.fmt = 3'd2; e.imm = sext({20'b0, w[31:25], w[11:7]}, 12); end
            7'b0110011: e.fmt = 3'd0;
            default: known = 1'b0;
        endcase
        e.rs1u = (e.fmt inside {3'd1, 3'd2, 3'd3}) || (op == 7'b0110011);
        e.rs2u = (e.fmt inside {3'd2, 3'd3}) || (op == 7'b0110011);
        e.rdwe = ((e.fmt inside {3'd1, 3'd4, 3'd5}) || (op == 7'b0110011)) && (w[11:7] != 5'd0);
        e.ill = 1'b0;
        if (ILL_EN) begin
            e.ill = !known || (w[1:0] != 2'b11) ||
                    (op == 7'b1100111 && f3 != 3'd0) ||
                    (op == 7'b1100011 && (f3 == 3'd2 || f3 == 3'd3)) ||
                    (op == 7'b0110011 && !(w[31:25] inside {7'b0000000, 7'b0100000}));
            if (e.ill) begin
                e.rs1u = 1'b0;
                e.rs2u = 1'b0;
                e.rdwe = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic check_flow(input string tag, input logic exp_valid, input logic exp_ready);
        check($sformatf("%s out_valid", tag), out_valid, exp_valid);
        check($sformatf("%s in_ready", tag), in_ready, exp_ready);
        check($sformatf("%s out_valid64", tag), out_valid_w, exp_valid);
        check($sformatf("%s in_ready64", tag), in_ready_w, exp_ready);
    endtask

    task automatic check_payload(input string tag, input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        e = ref_decode(w);
        check($sformatf("%s pc", tag), out_pc, pc);
        check($sformatf("%s opcode", tag), opcode, w[6:0]);
        check($sformatf("%s func3", tag), func3, w[14:12]);
        check($sformatf("%s func7", tag), func7, w[30]);
        check($sformatf("%s rs1", tag), Rs1, w[19:15]);
        check($sformatf("%s rs2", tag), Rs2, w[24:20]);
        check($sformatf("%s rd", tag), Rd, w[11:7]);
        check($sformatf("%s imme", tag), imme, e.imm[31:0]);
        check($sformatf("%s fmt", tag), imm_fmt, e.fmt);
        check($sformatf("%s flags", tag), {rs1_used, rs2_used, rd_we, illegal},
              {e.rs1u, e.rs2u, e.rdwe, e.ill});
        check($sformatf("%s pc64", tag), out_pc_w, pc);
        check($sformatf("%s fields64", tag), {opcode_w, func3_w, func7_w, Rs1_w, Rs2_w, Rd_w},
              {w[6:0], w[14:12], w[30], w[19:15], w[24:20], w[11:7]});
        check($sformatf("%s imme64", tag), imme_w, e.imm);
        check($sformatf("%s fmt64", tag), imm_fmt_w, e.fmt);
        check($sformatf("%s flags64", tag), {rs1_used_w, rs2_used_w, rd_we_w, illegal_w},
              {e.rs1u, e.rs2u, e.rdwe, e.ill});
    endtask

    initial begin
        vec_t  vecs [13];
        item_t q [$];
        item_t it;
        logic [31:0] w;
        int r;
        bit acc, emi;

        vecs[0]  = '{32'hFFF00093, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 5'd1,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'hFE112E23, 32'h104, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 32'h108, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 5'd29, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h7F8000EF, 32'h10C, 64'h0000_0000_0000_07F8, 3'd5, 5'd1,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h123452B7, 32'h110, 64'h0000_0000_1234_5000, 3'd4, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h800002B7, 32'h114, 64'hFFFF_FFFF_8000_0000, 3'd4, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFFFF117, 32'h118, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 5'd2,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h002081B3, 32'h11C, 64'h0,                   3'd0, 5'd3,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h00008067, 32'h120, 64'h0,                   3'd1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h00000013, 32'h124, 64'h0,                   3'd1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h00000000, 32'h128, 64'h0,                   3'd0, 5'd0,  1'b0, 1'b0, 1'b0, ILL_EN};
        vecs[11] = '{32'h00009067, 32'h12C, 64'h0,                   3'd1, 5'd0,  !ILL_EN, 1'b0, 1'b0, ILL_EN};
        vecs[12] = '{32'h022081B3, 32'h130, 64'h0,                   3'd0, 5'd3,  !ILL_EN, !ILL_EN, !ILL_EN, ILL_EN};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        #3;
        check_flow("reset", 1'b0, 1'b1);
        check("reset payload", {out_pc, opcode, func3, func7, Rs1, Rs2, Rd, imme}, 64'd0);
        check("reset fmt_flags", {imm_fmt, rs1_used, rs2_used, rd_we, illegal}, 7'd0);
        check("reset imme64", imme_w, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors, streamed back to back with out_ready held high.
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc; out_ready = 1'b1;
            @(posedge clk); #1;
            check_flow($sformatf("vec%0d", i), 1'b1, 1'b1);
            check($sformatf("vec%0d pc", i), out_pc, vecs[i].pc);
            check($sformatf("vec%0d imme", i), imme, vecs[i].imm64[31:0]);
            check($sformatf("vec%0d imme64", i), imme_w, vecs[i].imm64);
            check($sformatf("vec%0d fmt", i), imm_fmt, vecs[i].fmt);
            check($sformatf("vec%0d rd", i), Rd, vecs[i].rd);
            check($sformatf("vec%0d flags", i), {rs1_used, rs2_used, rd_we},
                  {vecs[i].rs1u, vecs[i].rs2u, vecs[i].rdwe});
            check($sformatf("vec%0d illegal", i), illegal, vecs[i].ill);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_flow("drain", 1'b0, 1'b1);

        // Three-cycle stall: main holds A, skid takes B, C waits for in_ready.
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200; out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall A first", out_pc, 32'h200);
        in_instr = 32'h00200113; in_pc = 32'h204; out_ready = 1'b0;
        @(posedge clk); #1;
        check_flow("stall1", 1'b1, 1'b0);
        check("stall1 pc", out_pc, 32'h200);
        in_instr = 32'h00300193; in_pc = 32'h208;
        @(posedge clk); #1;
        check_flow("stall2", 1'b1, 1'b0);
        check("stall2 pc", out_pc, 32'h200);
        check("stall2 imme", imme, 32'h1);
        @(posedge clk); #1;
        check_flow("stall3", 1'b1, 1'b0);
        check("stall3 rd", Rd, 5'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_flow("release B", 1'b1, 1'b1);
        check("release B pc", out_pc, 32'h204);
        @(posedge clk); #1;
        check("release C pc", out_pc, 32'h208);
        check("release C rd", Rd, 5'd3);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_flow("release empty", 1'b0, 1'b1);

        // Flush with both entries full and input offered.
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300; out_ready = 1'b1;
        @(posedge clk); #1;
        in_instr = 32'h00200113; in_pc = 32'h304; out_ready = 1'b0;
        @(posedge clk); #1;
        check_flow("pre-flush", 1'b1, 1'b0);
        in_instr = 32'h00300193; in_pc = 32'h308; flush = 1'b1;
        @(posedge clk); #1;
        check_flow("flush full", 1'b0, 1'b1);
        // Flush while the input would otherwise be accepted.
        in_instr = 32'h00400213; in_pc = 32'h30C; out_ready = 1'b1;
        @(posedge clk); #1;
        check_flow("flush accept", 1'b0, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check_flow("post-flush", 1'b0, 1'b1);

        // Random traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 1'b0;
                #2;
                check_flow("midreset", 1'b0, 1'b1);
                q.delete();
                rst_n = 1'b1;
            end
            w = $urandom;
            r = $urandom_range(0, 9);
            if (r < 9) w[6:0] = ops[r];
            if (w[6:0] == 7'b0110011 && $urandom_range(0, 1) == 1)
                w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
            if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
            in_instr  = w;
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            @(posedge clk);
            acc = in_valid && (q.size() < 2);
            emi = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (emi) void'(q.pop_front());
                if (acc) begin
                    it.instr = in_instr;
                    it.pc = in_pc;
                    q.push_back(it);
                end
            end
            #1;
            check_flow($sformatf("rnd%0d", c), q.size() > 0, q.size() < 2);
            if (q.size() > 0) check_payload($sformatf("rnd%0d", c), q[0].instr, q[0].pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
